note_sequencer: RTL and testbench
=================================

# note_sequencer

Song-step sequencer feeding the note index input of the square-wave voice generators. Walks a 6-bit note index from 0 to SONG_LEN-1 at a selectable tempo derived from CLOCK_50, with start/stop/pause control. Emits a rest index when idle so the downstream voices output zero amplitude.

## Interface
- SONG_LEN, default 47: number of steps; indices 0..SONG_LEN-1; legal range 1..63.
- BASE_TICKS, default 6_250_000: CLOCK_50 cycles per step at tempo_sel=0 (0.125 s); legal range 8..2^24-1.
- CLOCK_50  in  1  system clock, 50 MHz.
- reset  in  1  synchronous, active-high.
- start  in  1  pulse; (re)start the song from step 0.
- stop  in  1  pulse; abort to idle, no done.
- pause  in  1  level; freeze tempo count and note while high.
- tempo_sel  in  2  step period = BASE_TICKS >> tempo_sel.
- note  out  6  current step index to voice generators; REST_NOTE (63) when not playing.
- step  out  1  one-cycle pulse on every cycle in which note takes a new song index.
- playing  out  1  high in PLAY state, including while paused.
- done  out  1  one-cycle pulse when the last step's period expires.

## Operation
- States: IDLE, PLAY, DONE. Reset: state=IDLE, note=63, step=0, playing=0, done=0, tick count=0.
- IDLE: note=63. start -> PLAY; next edge note=0, count=0, step=1, playing=1.
- PLAY: each cycle with pause=0, count increments. When count >= period-1 (>= so a mid-step tempo_sel change to a shorter period never overruns): count=0 and
  - note < SONG_LEN-1: note=note+1, step=1.
  - note == SONG_LEN-1: state=DONE, note=63, playing=0, done=1.
- pause=1 in PLAY: count and note held, no step; playing stays 1. Pause in IDLE/DONE has no effect.
- DONE lasts exactly one cycle, then IDLE. start during DONE -> PLAY at step 0 (no IDLE cycle).
- start in PLAY (paused or not): restart — note=0, count=0, step=1.
- stop in PLAY/DONE: next edge IDLE, note=63, playing=0, no done, no step.
- Simultaneous start and stop: stop wins. Simultaneous start and period expiry: start wins (note=0).
- reset has priority over all inputs; mid-song reset yields reset values on the next edge.
- Period arithmetic: 24-bit count; period = BASE_TICKS >> tempo_sel, evaluated every cycle from the live tempo_sel.

## Timing
- All outputs registered; no combinational input-to-output paths.
- start sampled at edge N -> note=0, step=1, playing=1 after edge N.
- Step k occupies exactly period cycles of unpaused PLAY; a pause of P cycles extends it by P.
- done asserts in the same cycle note returns to 63 and playing falls.
- step and done are never high together except under SEQ_LOOP_EN wrap.

## Configuration
- SEQ_LOOP_EN defined: at last-step expiry note=0, step=1, done=1 (wrap marker), state stays PLAY, playing stays 1; DONE state unreachable. stop is the only exit.
- SEQ_LOOP_EN undefined: single-shot behaviour above.

## Structure
- Shared package audio_pkg: NOTE_W=6, REST_NOTE=6'd63, TICK_W=24, sequencer state enum (IDLE/PLAY/DONE).
- Sub-module tempo_divider: 24-bit count, period compute from BASE_TICKS and tempo_sel, enable (=PLAY & ~pause), clear, expire pulse output. FSM and note register stay in note_sequencer.

## Test plan
- BASE_TICKS=8, SONG_LEN=4, tempo_sel=0; pulse start -> note 0,1,2,3 each held 8 cycles, step pulse at each change, then note=63, done=1 for one cycle, playing=0.
- tempo_sel=2 (period 2) -> each note held 2 cycles; switch tempo_sel 0->3 at count 5 mid-step -> advance on next cycle, no overrun.
- pause high 10 cycles during note 1 -> note 1 lasts 18 cycles, playing stays 1, no step during pause.
- start at note 2 -> note=0, step=1 next cycle; start+stop same cycle -> IDLE, note=63, no done.
- reset asserted during note 2 -> next cycle note=63, playing=0, step=0, done=0; following start begins at 0.
- SEQ_LOOP_EN defined, SONG_LEN=4 -> after note 3 expires: note=0, step=1, done=1 same cycle, playing stays 1 across three loops; stop -> note=63.

Source files
------------

// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared widths, rest index and sequencer state encoding
package audio_pkg;

  localparam int NOTE_W = 6;
  localparam logic [NOTE_W-1:0] REST_NOTE = 6'd63;
  localparam int TICK_W = 24;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    DONE = 2'd2
  } seq_state_t;

  // Step period in CLOCK_50 cycles for a given tempo selection
  function automatic logic [TICK_W-1:0] step_period(input logic [TICK_W-1:0] base,
                                                    input logic [1:0] sel);
    return base >> sel;
  endfunction

endpackage

// File: rtl/tempo_divider.sv
// rtl/tempo_divider.sv - per-step tick counter with live tempo period and expire pulse
import audio_pkg::*;

module tempo_divider #(
  parameter int BASE_TICKS = 6_250_000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       enable,
  input  logic       clear,
  input  logic [1:0] tempo_sel,
  output logic       expire
);

  localparam logic [TICK_W-1:0] BASE = TICK_W'(BASE_TICKS);

  logic [TICK_W-1:0] count;
  logic [TICK_W-1:0] period;

  // Period follows tempo_sel every cycle; >= lets a shorter period cut the step short
  always_comb begin
    period = step_period(BASE, tempo_sel);
    expire = enable && (count >= (period - TICK_W'(1)));
  end

  // Count enabled cycles of the current step, wrapping on expiry
  always_ff @(posedge CLOCK_50) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= expire ? '0 : count + TICK_W'(1);
    end
  end

endmodule

// File: rtl/note_sequencer.sv
// rtl/note_sequencer.sv - song-step sequencer; SEQ_LOOP_EN selects looping playback
import audio_pkg::*;

module note_sequencer #(
  parameter int SONG_LEN   = 47,
  parameter int BASE_TICKS = 6_250_000
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  input  logic [1:0]        tempo_sel,
  output logic [NOTE_W-1:0] note,
  output logic              step,
  output logic              playing,
  output logic              done
);

  localparam logic [NOTE_W-1:0] LAST_NOTE = NOTE_W'(SONG_LEN - 1);

  seq_state_t state;
  logic       expire;
  logic       tick_enable;
  logic       tick_clear;

  // Count only while actively playing; any start/stop or non-PLAY state restarts the step
  always_comb begin
    tick_enable = (state == PLAY) && !pause;
    tick_clear  = start || stop || (state != PLAY);
  end

  tempo_divider #(
    .BASE_TICKS (BASE_TICKS)
  ) u_tempo_divider (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .enable    (tick_enable),
    .clear     (tick_clear),
    .tempo_sel (tempo_sel),
    .expire    (expire)
  );

  // Sequencer FSM with registered note/step/playing/done; stop beats start beats expiry
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state   <= IDLE;
      note    <= REST_NOTE;
      step    <= 1'b0;
      playing <= 1'b0;
      done    <= 1'b0;
    end else begin
      step <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start && !stop) begin
            state   <= PLAY;
            note    <= '0;
            step    <= 1'b1;
            playing <= 1'b1;
          end else begin
            state   <= IDLE;
            note    <= REST_NOTE;
            playing <= 1'b0;
          end
        end
        PLAY: begin
          if (stop) begin
            state   <= IDLE;
            note    <= REST_NOTE;
            playing <= 1'b0;
          end else if (start) begin
            note <= '0;
            step <= 1'b1;
          end else if (expire) begin
            if (note < LAST_NOTE) begin
              note <= note + NOTE_W'(1);
              step <= 1'b1;
            end else begin
`ifdef SEQ_LOOP_EN
              note <= '0;
              step <= 1'b1;
              done <= 1'b1;
`else
              state   <= DONE;
              note    <= REST_NOTE;
              playing <= 1'b0;
              done    <= 1'b1;
`endif
            end
          end
        end
        default: begin
          state   <= IDLE;
          note    <= REST_NOTE;
          playing <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_note_sequencer.sv
// tb/tb_note_sequencer.sv - scenario and randomized checks of note_sequencer against a song model
module tb_note_sequencer;

  localparam int SONG_LEN   = 4;
  localparam int BASE_TICKS = 8;

  logic       CLOCK_50 = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       pause = 1'b0;
  logic [1:0] tempo_sel = 2'd0;
  logic [5:0] note;
  logic       step;
  logic       playing;
  logic       done;

  int n_checks = 0;
  int n_fail = 0;

  // Song model: "on" while a song runs, idx is the song position, elapsed the cycles spent on it
  bit         m_on = 0;
  int         m_idx = 0;
  int         m_elapsed = 0;
  logic [5:0] m_note = 6'd63;
  logic       m_step = 1'b0;
  logic       m_playing = 1'b0;
  logic       m_done = 1'b0;

  note_sequencer #(
    .SONG_LEN   (SONG_LEN),
    .BASE_TICKS (BASE_TICKS)
  ) dut (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .start     (start),
    .stop      (stop),
    .pause     (pause),
    .tempo_sel (tempo_sel),
    .note      (note),
    .step      (step),
    .playing   (playing),
    .done      (done)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One clock edge with the current inputs; the model advances by the song rules
  task automatic clk();
    bit r, s, sp, ps;
    int per;
    r = reset; s = start; sp = stop; ps = pause;
    per = BASE_TICKS >> tempo_sel;
    @(posedge CLOCK_50);
    #1;
    m_step = 0;
    m_done = 0;
    if (r) begin
      m_on = 0; m_elapsed = 0; m_note = 6'd63; m_playing = 0;
    end else if (sp) begin
      m_on = 0; m_note = 6'd63; m_playing = 0;
    end else if (s) begin
      m_on = 1; m_idx = 0; m_elapsed = 0; m_note = 6'd0; m_step = 1; m_playing = 1;
    end else if (m_on && !ps) begin
      m_elapsed++;
      if (m_elapsed >= per) begin
        m_elapsed = 0;
        if (m_idx < SONG_LEN - 1) begin
          m_idx++;
          m_note = 6'(m_idx);
          m_step = 1;
        end else begin
`ifdef SEQ_LOOP_EN
          m_idx = 0; m_note = 6'd0; m_step = 1; m_done = 1;
`else
          m_on = 0; m_note = 6'd63; m_playing = 0; m_done = 1;
`endif
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1; start = 0; stop = 0; pause = 0; tempo_sel = 0;
    clk(); clk();
    n_checks++; if (note !== 6'd63) begin n_fail++; $display("FAIL reset_note: got %0d expected 63", note); end
    n_checks++; if (step !== 1'b0) begin n_fail++; $display("FAIL reset_step: got %b expected 0", step); end
    n_checks++; if (playing !== 1'b0) begin n_fail++; $display("FAIL reset_playing: got %b expected 0", playing); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    reset = 0;
    pause = 1; clk(); pause = 0;
    n_checks++; if (note !== 6'd63 || playing !== 1'b0) begin n_fail++; $display("FAIL idle_pause: note %0d playing %b expected 63/0", note, playing); end
  endtask

  task automatic test_full_song();
    int held [SONG_LEN];
    int steps;
    bit seen_done;
    foreach (held[k]) held[k] = 0;
    tempo_sel = 0;
    start = 1; clk(); start = 0;
    n_checks++; if (note !== 6'd0 || step !== 1'b1 || playing !== 1'b1) begin n_fail++; $display("FAIL song_start: note %0d step %b playing %b expected 0/1/1", note, step, playing); end
    steps = 1;
    seen_done = 0;
    for (int i = 0; i < 60 && !seen_done; i++) begin
      if (note < SONG_LEN) held[note]++;
      clk();
      if (step) steps++;
      n_checks++; if (note !== m_note) begin n_fail++; $display("FAIL song_note: got %0d expected %0d", note, m_note); end
      if (done) begin
        seen_done = 1;
`ifdef SEQ_LOOP_EN
        n_checks++; if (note !== 6'd0 || playing !== 1'b1 || step !== 1'b1) begin n_fail++; $display("FAIL song_wrap: note %0d playing %b step %b expected 0/1/1", note, playing, step); end
`else
        n_checks++; if (note !== 6'd63 || playing !== 1'b0 || step !== 1'b0) begin n_fail++; $display("FAIL song_done: note %0d playing %b step %b expected 63/0/0", note, playing, step); end
`endif
      end
    end
    n_checks++; if (!seen_done) begin n_fail++; $display("FAIL song_done_timeout: done %b expected 1 within 60 cycles", seen_done); end
    for (int k = 0; k < SONG_LEN; k++) begin
      n_checks++; if (held[k] != BASE_TICKS) begin n_fail++; $display("FAIL song_hold_%0d: got %0d cycles expected %0d", k, held[k], BASE_TICKS); end
    end
`ifdef SEQ_LOOP_EN
    n_checks++; if (steps != SONG_LEN + 1) begin n_fail++; $display("FAIL song_steps: got %0d expected %0d", steps, SONG_LEN + 1); end
    stop = 1; clk(); stop = 0;
`else
    n_checks++; if (steps != SONG_LEN) begin n_fail++; $display("FAIL song_steps: got %0d expected %0d", steps, SONG_LEN); end
    clk();
`endif
    n_checks++; if (done !== 1'b0 || note !== 6'd63) begin n_fail++; $display("FAIL song_after: done %b note %0d expected 0/63", done, note); end
  endtask

  task automatic test_tempo();
    int run;
    bit bad_hold;
    tempo_sel = 2;
    start = 1; clk(); start = 0;
    run = 1;
    bad_hold = 0;
    for (int i = 0; i < 2 * (SONG_LEN - 1); i++) begin
      clk();
      if (step) begin
        if (run != 2) bad_hold = 1;
        run = 1;
      end else begin
        run++;
      end
    end
    n_checks++; if (bad_hold || note !== 6'(SONG_LEN - 1)) begin n_fail++; $display("FAIL tempo2_hold: note %0d bad_hold %b expected %0d/0", note, bad_hold, SONG_LEN - 1); end
    tempo_sel = 0;
    start = 1; clk(); start = 0;
    for (int i = 0; i < 5; i++) clk();
    n_checks++; if (note !== 6'd0) begin n_fail++; $display("FAIL tempo_mid: got note %0d expected 0", note); end
    tempo_sel = 3;
    clk();
    n_checks++; if (note !== 6'd1 || step !== 1'b1) begin n_fail++; $display("FAIL tempo_switch: note %0d step %b expected 1/1", note, step); end
    n_checks++; if (note !== m_note) begin n_fail++; $display("FAIL tempo_model: got %0d expected %0d", note, m_note); end
    stop = 1; tempo_sel = 0; clk(); stop = 0;
  endtask

  task automatic test_pause();
    int dur;
    bit p;
    tempo_sel = 0;
    start = 1; clk(); start = 0;
    for (int i = 0; i < 40 && note != 6'd1; i++) clk();
    dur = 0;
    for (int i = 0; i < 40 && note == 6'd1; i++) begin
      dur++;
      pause = (dur >= 3 && dur < 13);
      p = pause;
      clk();
      if (p) begin
        n_checks++; if (step !== 1'b0 || playing !== 1'b1) begin n_fail++; $display("FAIL pause_hold: step %b playing %b expected 0/1", step, playing); end
      end
    end
    pause = 0;
    n_checks++; if (dur != 18) begin n_fail++; $display("FAIL pause_duration: got %0d cycles expected 18", dur); end
    n_checks++; if (note !== 6'd2 || step !== 1'b1) begin n_fail++; $display("FAIL pause_resume: note %0d step %b expected 2/1", note, step); end
    stop = 1; clk(); stop = 0;
  endtask

  task automatic test_restart();
    start = 1; clk(); start = 0;
    for (int i = 0; i < 40 && note != 6'd2; i++) clk();
    clk(); clk();
    start = 1; clk(); start = 0;
    n_checks++; if (note !== 6'd0 || step !== 1'b1 || playing !== 1'b1) begin n_fail++; $display("FAIL restart: note %0d step %b playing %b expected 0/1/1", note, step, playing); end
    clk();
    start = 1; stop = 1; clk(); start = 0; stop = 0;
    n_checks++; if (note !== 6'd63 || playing !== 1'b0 || done !== 1'b0 || step !== 1'b0) begin n_fail++; $display("FAIL start_stop: note %0d playing %b done %b step %b expected 63/0/0/0", note, playing, done, step); end
  endtask

  task automatic test_reset_mid();
    start = 1; clk(); start = 0;
    for (int i = 0; i < 40 && note != 6'd2; i++) clk();
    reset = 1; clk(); reset = 0;
    n_checks++; if (note !== 6'd63 || playing !== 1'b0 || step !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL reset_mid: note %0d playing %b step %b done %b expected 63/0/0/0", note, playing, step, done); end
    start = 1; clk(); start = 0;
    n_checks++; if (note !== 6'd0 || step !== 1'b1) begin n_fail++; $display("FAIL reset_restart: note %0d step %b expected 0/1", note, step); end
    stop = 1; clk(); stop = 0;
  endtask

`ifdef SEQ_LOOP_EN
  task automatic test_loop();
    int wraps;
    start = 1; clk(); start = 0;
    wraps = 0;
    for (int i = 0; i < 200 && wraps < 3; i++) begin
      clk();
      n_checks++; if (playing !== 1'b1) begin n_fail++; $display("FAIL loop_playing: got %b expected 1", playing); end
      if (done) begin
        wraps++;
        n_checks++; if (note !== 6'd0 || step !== 1'b1) begin n_fail++; $display("FAIL loop_wrap: note %0d step %b expected 0/1", note, step); end
      end
    end
    n_checks++; if (wraps != 3) begin n_fail++; $display("FAIL loop_count: got %0d wraps expected 3", wraps); end
    stop = 1; clk(); stop = 0;
    n_checks++; if (note !== 6'd63 || playing !== 1'b0) begin n_fail++; $display("FAIL loop_stop: note %0d playing %b expected 63/0", note, playing); end
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 299) == 0);
      start = ($urandom_range(0, 49) == 0);
      stop = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 7) == 0) pause = ~pause;
      if ($urandom_range(0, 29) == 0) tempo_sel = 2'($urandom_range(0, 3));
      clk();
      n_checks++; if (note !== m_note) begin n_fail++; $display("FAIL rand_note@%0d: got %0d expected %0d", i, note, m_note); end
      n_checks++; if (step !== m_step) begin n_fail++; $display("FAIL rand_step@%0d: got %b expected %b", i, step, m_step); end
      n_checks++; if (playing !== m_playing) begin n_fail++; $display("FAIL rand_playing@%0d: got %b expected %b", i, playing, m_playing); end
      n_checks++; if (done !== m_done) begin n_fail++; $display("FAIL rand_done@%0d: got %b expected %b", i, done, m_done); end
    end
    reset = 0; start = 0; stop = 0; pause = 0; tempo_sel = 0;
  endtask

  initial begin
    test_reset();
    test_full_song();
    test_tempo();
    test_pause();
    test_restart();
    test_reset_mid();
`ifdef SEQ_LOOP_EN
    test_loop();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
